count_enable_ctrl: RTL
======================

# count_enable_ctrl

Front-end control stage that drives the `enable` input of the 4-bit up counter. It conditions two raw push-button inputs:
- a run/stop toggle;
- a single-step request.

From these it produces a registered, one-cycle `enable` pulse train at a programmable rate while running, or a single pulse per step press while stopped. Its `enable` output connects directly to the counter's `enable`; both blocks share `clk` and `reset`.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required to accept a button level change; legal range ≥1.
- `PRESCALE`, default 10: enable period in `clk` cycles while running; legal range ≥1.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `btn_run`  in  1  raw, asynchronous run/stop button, active-high.
- `btn_step`  in  1  raw, asynchronous single-step button, active-high.
- `enable`  out  1  registered enable to counter; one-cycle pulses.
- `running`  out  1  registered; 1 in RUNNING state.

## Operation
- **Synchronizer:** each button passes through a 2-flop synchronizer (`s1 <= raw`, `s2 <= s1`).
- **Debouncer, per button:**
  - Holds a debounced level `db` and a counter `cnt` of width `$clog2(DEBOUNCE_CYCLES)+1`.
  - If `s2 != db`: `cnt` increments. When `cnt == DEBOUNCE_CYCLES-1`, then `db <= s2` and `cnt <= 0`.
  - If `s2 == db`: `cnt <= 0`.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes `db`.
- **Press detect:** `press = db & ~db_q`, where `db_q` is `db` delayed one cycle. It is a combinational single-cycle pulse on each debounced rising edge. Release edges are ignored.
- **FSM states:** STOPPED, RUNNING.
  - STOPPED, `run_press` → RUNNING; prescaler cleared to 0.
  - STOPPED, `step_press` with no `run_press` → stay STOPPED; `enable <= 1` for exactly one cycle.
  - STOPPED, `run_press` and `step_press` in the same cycle → run wins; step dropped; no enable pulse.
  - RUNNING, `run_press` → STOPPED; `enable <= 0` at the same edge; prescaler cleared.
  - RUNNING, `step_press` → ignored.
- **Prescaler:**
  - Width `$clog2(PRESCALE)+1`; active only in RUNNING.
  - Increments each cycle. When it equals `PRESCALE-1` it wraps to 0 and `enable <= 1`; otherwise `enable <= 0`.
  - `PRESCALE == 1` → `enable` is held high continuously while running.
- **Reset:** synchronous and dominant over all other inputs. Forces:
  - STOPPED; `enable = 0`; `running = 0`;
  - all synchronizer, `db`, `db_q`, `cnt` and prescaler registers to 0.
  - Reset mid-run drops `enable` and `running` at the reset edge. A button held through reset is re-debounced from 0, so one press is detected after release of reset.

## Timing
- Numbering: edge 1 is the first rising edge that samples a raw button high.
- Debounced level rises after edge `D+2`, where D = `DEBOUNCE_CYCLES`.
- `running` rises after edge `D+3` (edge 7 for D=4). A step `enable` pulse occurs in the same cycle.
- The first `enable` pulse after entering RUNNING occurs after edge `D+3+PRESCALE`, then repeats every `PRESCALE` cycles.
- Stop latency is identical: `running` falls after edge `D+3` of the press, and `enable` is 0 from that edge onward.
- Outputs are glitch-free registers. `enable` is never high for 2 consecutive cycles unless `PRESCALE == 1`.
- Release then re-press requires the level to hold ≥D cycles in each phase to register as a new press.

## Test plan
- **Reset:** reset=1 for 2 cycles, buttons low → `enable=0`, `running=0`. Hold 20 cycles with no stimulus → no `enable` pulse.
- **Run with bounce:** D=4, P=10. Toggle `btn_run` 1/0/1 at 1-cycle spacing, then hold high 8 cycles, then release → exactly one `running` rise. First `enable` arrives 10 cycles after `running` rises; pulses repeat every 10 cycles; the downstream counter reads 3 after 30 running cycles.
- **Glitch rejection:** `btn_step` high for 3 cycles with D=4 → no `enable` pulse, `running` stays 0.
- **Single-step:** while STOPPED, 5 clean step presses (each high 6, low 6 cycles) → exactly 5 one-cycle `enable` pulses; downstream count = 5.
- **Simultaneous and ignored presses:**
  - Assert `btn_run` and `btn_step` on the same edge from STOPPED → RUNNING entered, no step pulse.
  - Step press while RUNNING → pulse spacing unchanged at 10.
- **Reset mid-run:** assert reset between prescaler counts 5 and 6 → `enable`/`running` go 0 at the reset edge. With `btn_run` held through reset, RUNNING re-entered D+3 edges after reset deasserts; first pulse arrives P cycles later.

Source files
------------

// File: rtl/count_enable_ctrl.sv
// Enable generator for the 4-bit up counter: debounces run/stop and single-step
// buttons and emits one-cycle enable pulses at a programmable rate or per step.
module count_enable_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned PRESCALE        = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_run,
  input  logic btn_step,
  output logic enable,
  output logic running
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned PW = $clog2(PRESCALE) + 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  typedef enum logic {
    STOPPED,
    RUNNING
  } state_e;

  // Bit 0 carries the run/stop button, bit 1 the single-step button.
  logic [1:0]         raw;
  logic [1:0]         sync1_q, sync1_d;
  logic [1:0]         sync2_q, sync2_d;
  logic [1:0]         db_q, db_d;
  logic [1:0]         db_dly_q, db_dly_d;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic [1:0]         press;

  state_e             state_q, state_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic               enable_q, enable_d;
  logic               running_q, running_d;

  assign raw   = {btn_step, btn_run};
  assign press = db_q & ~db_dly_q;

  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    db_dly_d = db_q;
    db_d     = db_q;
    cnt_d    = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      // The level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          db_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    enable_d = 1'b0;
    case (state_q)
      STOPPED: begin
        // A run press takes priority over a simultaneous step press.
        if (press[0]) begin
          state_d = RUNNING;
          presc_d = '0;
        end else if (press[1]) begin
          enable_d = 1'b1;
        end
      end
      RUNNING: begin
        if (press[0]) begin
          state_d = STOPPED;
          presc_d = '0;
        end else if (presc_q == PS_LAST) begin
          presc_d  = '0;
          enable_d = 1'b1;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
    endcase
    running_d = (state_d == RUNNING);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_dly_q  <= '0;
      cnt_q     <= '0;
      state_q   <= STOPPED;
      presc_q   <= '0;
      enable_q  <= 1'b0;
      running_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_q      <= db_d;
      db_dly_q  <= db_dly_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      presc_q   <= presc_d;
      enable_q  <= enable_d;
      running_q <= running_d;
    end
  end

  assign enable  = enable_q;
  assign running = running_q;

endmodule
